sram_bist: RTL and testbench

- Built-in self-test initiator for the single-port synchronous `sram`.
- It drives the memory's `we`/`addr`/`din` side and checks `dout`, taking the place of a hand-written bench stimulus.
- It runs a March C- sequence over every address, compares each read against the expected background, and reports pass/fail with first-failure capture.
- It sits between the top-level test/control logic and the SRAM macro's port.

---
 rtl/sram_bist_pkg.sv | 38 +++
 rtl/sram_bist_addr_gen.sv | 44 ++++
 rtl/sram_bist.sv | 192 +++++++++++++++++++
 tb/tb_sram_bist.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types for the March C- SRAM self-test: ops, directions, element table, FSM states.
// The element table is walked by sram_bist; each entry is {dir, op1, op2}.
package sram_bist_pkg;

    typedef logic [2:0] elem_t;
    localparam elem_t LAST_ELEM = 3'd5;

    typedef enum logic [2:0] {OP_NONE, OP_R0, OP_R1, OP_W0, OP_W1} op_e;
    typedef enum logic {DIR_UP, DIR_DN} dir_e;

    typedef struct packed {
        dir_e dir;
        op_e  op1;
        op_e  op2;
    } march_t;

    localparam march_t [0:5] MARCH_TBL = '{
        '{DIR_UP, OP_W0, OP_NONE},
        '{DIR_UP, OP_R0, OP_W1},
        '{DIR_UP, OP_R1, OP_W0},
        '{DIR_DN, OP_R0, OP_W1},
        '{DIR_DN, OP_R1, OP_W0},
        '{DIR_UP, OP_R0, OP_NONE}
    };

    typedef enum logic [2:0] {
        ST_IDLE, ST_RD_ISSUE, ST_RD_WAIT, ST_RD_CMP, ST_WR, ST_DONE
    } state_e;

    function automatic state_e op_state(input op_e op);
        case (op)
            OP_R0, OP_R1: op_state = ST_RD_ISSUE;
            OP_W0, OP_W1: op_state = ST_WR;
            default:      op_state = ST_DONE;
        endcase
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down March address counter: load jumps to the element start, step moves one address.
// last_o flags the final address of the current direction; no wrap past either end is ever requested.
module sram_bist_addr_gen
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  dir_e              dir_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    dir_e              dir_q, dir_d;

    always_comb begin
        addr_d = addr_q;
        dir_d  = dir_q;
        if (load_i) begin
            dir_d  = dir_i;
            addr_d = (dir_i == DIR_UP) ? '0 : '1;
        end else if (step_i) begin
            addr_d = (dir_q == DIR_UP) ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            dir_q  <= DIR_UP;
        end else begin
            addr_q <= addr_d;
            dir_q  <= dir_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (dir_q == DIR_UP) ? (addr_q == '1) : (addr_q == '0);

endmodule

// File: rtl/sram_bist.sv
// March C- BIST initiator for a single-port synchronous SRAM with first-failure capture.
// Reads cost RD_LAT+1 cycles, writes one cycle; the SRAM never stalls, so there is no backpressure.
module sram_bist
    import sram_bist_pkg::*;
#(
    parameter int              ADDR_W       = 4,
    parameter int              DATA_W       = 8,
    parameter int              RD_LAT       = 1,
    parameter logic [DATA_W-1:0] BG         = '0,
    parameter bit              STOP_ON_FAIL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [2:0]        fail_elem,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_e            state_q, state_d;
    elem_t             elem_q, elem_d;
    logic              op_sel_q, op_sel_d;
    logic [1:0]        wait_q, wait_d;
    logic [7:0]        err_q, err_d;
    logic              pass_q, pass_d;
    elem_t             felem_q, felem_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [DATA_W-1:0] fexp_q, fexp_d, fgot_q, fgot_d;
    logic [DATA_W-1:0] din_q;

    logic        ag_load, ag_step, ag_last, advance, wr_en;
    dir_e        ag_dir;
    march_t      cur, nxt;
    op_e         cur_op;
    logic [DATA_W-1:0] pat;

    sram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ag_load),
        .step_i (ag_step),
        .dir_i  (ag_dir),
        .addr_o (mem_addr),
        .last_o (ag_last)
    );

    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        op_sel_d = op_sel_q;
        wait_d   = wait_q;
        err_d    = err_q;
        pass_d   = pass_q;
        felem_d  = felem_q;
        faddr_d  = faddr_q;
        fexp_d   = fexp_q;
        fgot_d   = fgot_q;
        ag_load  = 1'b0;
        ag_step  = 1'b0;
        ag_dir   = DIR_UP;
        advance  = 1'b0;
        wr_en    = 1'b0;
        cur      = MARCH_TBL[elem_q];
        nxt      = MARCH_TBL[elem_q + 3'd1];
        cur_op   = op_sel_q ? cur.op2 : cur.op1;
        pat      = (cur_op == OP_R1 || cur_op == OP_W1) ? ~BG : BG;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = op_state(MARCH_TBL[0].op1);
                    elem_d   = '0;
                    op_sel_d = 1'b0;
                    ag_load  = 1'b1;
                    ag_dir   = MARCH_TBL[0].dir;
                    err_d    = '0;
                    pass_d   = 1'b0;
                    felem_d  = '0;
                    faddr_d  = '0;
                    fexp_d   = '0;
                    fgot_d   = '0;
                end
            end
            ST_RD_ISSUE: begin
                if (RD_LAT == 1) begin
                    state_d = ST_RD_CMP;
                end else begin
                    state_d = ST_RD_WAIT;
                    wait_d  = 2'(RD_LAT - 2);
                end
            end
            ST_RD_WAIT: begin
                if (wait_q == 2'd0) state_d = ST_RD_CMP;
                else                wait_d  = wait_q - 2'd1;
            end
            ST_RD_CMP: begin
                advance = 1'b1;
                if (mem_dout != pat) begin
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    // err_cnt never returns to zero mid-run, so zero marks the first failure
                    if (err_q == 8'd0) begin
                        felem_d = elem_q;
                        faddr_d = mem_addr;
                        fexp_d  = pat;
                        fgot_d  = mem_dout;
                    end
                    if (STOP_ON_FAIL) begin
                        advance = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WR: begin
                wr_en   = 1'b1;
                advance = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (!op_sel_q && cur.op2 != OP_NONE) begin
                op_sel_d = 1'b1;
                state_d  = op_state(cur.op2);
            end else begin
                op_sel_d = 1'b0;
                if (!ag_last) begin
                    ag_step = 1'b1;
                    state_d = op_state(cur.op1);
                end else if (elem_q == LAST_ELEM) begin
                    state_d = ST_DONE;
                end else begin
                    elem_d  = elem_q + 3'd1;
                    ag_load = 1'b1;
                    ag_dir  = nxt.dir;
                    state_d = op_state(nxt.op1);
                end
            end
        end

        if (state_d == ST_DONE && state_q != ST_DONE) pass_d = (err_d == 8'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            elem_q   <= '0;
            op_sel_q <= 1'b0;
            wait_q   <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            felem_q  <= '0;
            faddr_q  <= '0;
            fexp_q   <= '0;
            fgot_q   <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            elem_q   <= elem_d;
            op_sel_q <= op_sel_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
            felem_q  <= felem_d;
            faddr_q  <= faddr_d;
            fexp_q   <= fexp_d;
            fgot_q   <= fgot_d;
            din_q    <= mem_din;
        end
    end

    // Write controls decode straight from the state register so reset kills mem_we at once
    assign mem_we    = wr_en;
    assign mem_din   = wr_en ? pat : din_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign fail_elem = felem_q;
    assign fail_addr = faddr_q;
    assign fail_exp  = fexp_q;
    assign fail_got  = fgot_q;

endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: two instances (STOP_ON_FAIL 0 and 1), each on a behavioural SRAM with optional stuck-at-1 fault.
module tb_sram_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    bit   fault = 1'b0;
    bit   sel = 1'b0;

    logic       busy0, done0, pass0, we0, busy1, done1, pass1, we1;
    logic [7:0] err0, err1, fx0, fg0, fx1, fg1, din0, din1, dout0, dout1;
    logic [2:0] fe0, fe1;
    logic [3:0] fa0, fa1, addr0, addr1;
    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];

    logic       c_busy, c_done, c_pass, c_we;
    logic [7:0] c_err, c_fx, c_fg;
    logic [2:0] c_fe;
    logic [3:0] c_fa;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_bist #(.STOP_ON_FAIL(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .fail_elem(fe0), .fail_addr(fa0), .fail_exp(fx0), .fail_got(fg0),
        .mem_we(we0), .mem_addr(addr0), .mem_din(din0), .mem_dout(dout0)
    );

    sram_bist #(.STOP_ON_FAIL(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_elem(fe1), .fail_addr(fa1), .fail_exp(fx1), .fail_got(fg1),
        .mem_we(we1), .mem_addr(addr1), .mem_din(din1), .mem_dout(dout1)
    );

    // Read latency 1; bit0 of address 5 reads back as 1 while the fault is on
    always @(posedge clk) begin
        if (we0) mem0[addr0] <= din0;
        if (we1) mem1[addr1] <= din1;
        dout0 <= mem0[addr0] | ((fault && addr0 == 4'd5) ? 8'h01 : 8'h00);
        dout1 <= mem1[addr1] | ((fault && addr1 == 4'd5) ? 8'h01 : 8'h00);
    end

    always_comb begin
        c_busy = sel ? busy1 : busy0;
        c_done = sel ? done1 : done0;
        c_pass = sel ? pass1 : pass0;
        c_we   = sel ? we1   : we0;
        c_err  = sel ? err1  : err0;
        c_fe   = sel ? fe1   : fe0;
        c_fa   = sel ? fa1   : fa0;
        c_fx   = sel ? fx1   : fx0;
        c_fg   = sel ? fg1   : fg0;
    end

    typedef struct {
        int fault;
        int sel;
        int mid_start;
        int exp_cyc;
        int exp_wr;
        int exp_pass;
        int exp_err;
        int exp_fe;
        int exp_fa;
        int exp_fx;
        int exp_fg;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic pulse_start(input bit s);
        sel = s;
        @(negedge clk);
        if (s) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Starts the selected DUT and counts cycles and writes until done (bounded)
    task automatic run_test(input bit s, input int mid_start, output int cyc, output int wr);
        pulse_start(s);
        check("busy_after_start", int'(c_busy), 1);
        check("done_after_start", int'(c_done), 0);
        cyc = 0;
        wr  = 0;
        while (!c_done && cyc < 2000) begin
            if (c_we) wr++;
            if (s) start1 = (mid_start != 0 && cyc == mid_start);
            else   start0 = (mid_start != 0 && cyc == mid_start);
            @(negedge clk);
            cyc++;
        end
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    initial begin
        int cyc, wr, k, p;

        vecs[0] = '{0, 1,  0, 240, 80, 1, 0, 0, 0, 0, 0};
        vecs[1] = '{0, 0, 50, 240, 80, 1, 0, 0, 0, 0, 0};
        vecs[2] = '{1, 1,  0,  33, 21, 0, 1, 1, 5, 0, 1};
        vecs[3] = '{1, 0,  0, 240, 80, 0, 3, 1, 5, 0, 1};
        vecs[4] = '{0, 1,  0, 240, 80, 1, 0, 0, 0, 0, 0};
        vecs[5] = '{0, 0,  0, 240, 80, 1, 0, 0, 0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end

        repeat (2) @(negedge clk);
        check("rst_busy0", int'(busy0), 0);
        check("rst_done0", int'(done0), 0);
        check("rst_pass0", int'(pass0), 0);
        check("rst_err0",  int'(err0),  0);
        check("rst_we0",   int'(we0),   0);
        check("rst_addr0", int'(addr0), 0);
        check("rst_din0",  int'(din0),  0);
        check("rst_fail0", int'({fe0, fa0, fx0, fg0}), 0);
        check("rst_busy1", int'(busy1), 0);
        check("rst_we1",   int'(we1),   0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            fault = (vecs[i].fault != 0);
            run_test(vecs[i].sel != 0, vecs[i].mid_start, cyc, wr);
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
            check($sformatf("v%0d_writes", i), wr, vecs[i].exp_wr);
            check($sformatf("v%0d_busy", i), int'(c_busy), 0);
            check($sformatf("v%0d_pass", i), int'(c_pass), vecs[i].exp_pass);
            check($sformatf("v%0d_err_cnt", i), int'(c_err), vecs[i].exp_err);
            check($sformatf("v%0d_fail_elem", i), int'(c_fe), vecs[i].exp_fe);
            check($sformatf("v%0d_fail_addr", i), int'(c_fa), vecs[i].exp_fa);
            check($sformatf("v%0d_fail_exp", i), int'(c_fx), vecs[i].exp_fx);
            check($sformatf("v%0d_fail_got", i), int'(c_fg), vecs[i].exp_fg);
        end

        // Port-level trace of E0 (ascending w0) and E3 (descending r0,w1)
        fault = 1'b0;
        pulse_start(1'b0);
        for (int c = 0; c < 240; c++) begin
            if (c < 16) begin
                check("e0_we",   int'(we0),   1);
                check("e0_addr", int'(addr0), c);
                check("e0_din",  int'(din0),  0);
            end else if (c >= 112 && c < 160) begin
                k = (c - 112) / 3;
                p = (c - 112) % 3;
                check("e3_addr", int'(addr0), 15 - k);
                check("e3_we",   int'(we0),   int'(p == 2));
                if (p == 2) check("e3_din", int'(din0), 8'hFF);
            end
            @(negedge clk);
        end
        check("trace_done", int'(done0), 1);
        check("trace_pass", int'(pass0), 1);

        // Asynchronous reset in the middle of a write around cycle 100
        pulse_start(1'b1);
        cyc = 0;
        while (!(cyc >= 100 && we1) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_we_before", int'(we1), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_we",    int'(we1),   0);
        check("rst_mid_busy",  int'(busy1), 0);
        check("rst_mid_done",  int'(done1), 0);
        check("rst_mid_done0", int'(done0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_test(1'b1, 0, cyc, wr);
        check("post_rst_cycles", cyc, 240);
        check("post_rst_pass", int'(pass1), 1);
        check("post_rst_err", int'(err1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
